wb_memtest: RTL and testbench
=============================

# wb_memtest

Parametrised pipelined Wishbone memory-test master. It sits between a control source (LEDs, debug bus, CPU register) and any pipelined Wishbone slave, typically `wbsdram` or a block RAM. It writes a selectable data pattern over an address range, reads the range back, and reports pass/fail, error count, first failing word and run time. Unlike a one-request-at-a-time tester, it keeps up to 2^LGOUT requests in flight and supports four pattern modes.

## Interface
- AW, 19: Wishbone word-address width.
- DW, 32: data width. Legal values are 8, 16 and 32.
- LGOUT, 3: log2 of the maximum number of outstanding requests.
- i_clk, input, 1: system clock.
- i_reset, input, 1: synchronous, active-high reset.
- i_start, input, 1: start pulse. Ignored while o_busy.
- i_mode, input, 2: pattern select. 0 = address, 1 = ~address, 2 = LFSR, 3 = checkerboard.
- i_seed, input, 32: LFSR seed. Sampled at start; a value of 0 is replaced by 1.
- i_last_addr, input, AW: last word address of the range tested. Sampled at start.
- o_wb_cyc, o_wb_stb, o_wb_we, output, 1 each: Wishbone master controls.
- o_wb_addr, output, AW: request address.
- o_wb_data, output, DW: write data.
- o_wb_sel, output, DW/8: byte selects, always all ones.
- i_wb_stall, i_wb_ack, i_wb_err, input, 1 each: slave responses.
- i_wb_data, input, DW: read data.
- o_busy, output, 1: test in progress.
- o_done, output, 1: test finished. Held until the next start.
- o_pass, output, 1: valid when o_done. High only if there were 0 mismatches and no bus error.
- o_bus_err, output, 1: an i_wb_err was seen.
- o_err_count, output, 16: read mismatches, saturating at 16'hFFFF.
- o_err_addr, output, AW: address of the first mismatch.
- o_err_exp, o_err_got, output, DW each: expected and received data of the first mismatch.
- o_cycles, output, 32: clocks from start to done, saturating.

## Operation
- States are IDLE, WRITE, WDRAIN, GAP, READ, RDRAIN, DONE.
- IDLE:
  - On i_start, sample i_mode, i_seed and i_last_addr.
  - Clear the error outputs, o_cycles and the counters.
  - Go to WRITE.
- WRITE: cyc=1, we=1.
  - stb is asserted whenever the outstanding count is below 2^LGOUT.
  - A request is accepted on stb && !stall. On accept, the issue address and issue pattern generator advance.
  - After accepting address i_last_addr, drop stb and go to WDRAIN.
- WDRAIN: wait for outstanding == 0, then drop cyc and go to GAP.
- GAP: exactly one cycle with cyc=0, then READ with issue address and generator reloaded.
- READ: same issue rules as WRITE, with we=0.
  - Each ack is compared against a separate check generator and check address, which advance once per ack. Responses return in order.
  - Mismatch: o_err_count++. The first mismatch latches o_err_addr, o_err_exp and o_err_got.
  - After the last accept, go to RDRAIN.
- RDRAIN: when outstanding == 0 and the final ack has been checked, drop cyc and go to DONE.
- DONE: o_done=1 and o_busy=0. i_start re-arms the test directly, as from IDLE.
- Outstanding counter, LGOUT+1 bits:
  - +1 on accept, −1 on ack.
  - Accept and ack in the same cycle leave it unchanged.
  - Issue limit: stb may be high only if outstanding < 2^LGOUT, or if outstanding == 2^LGOUT with an ack this cycle.
- Patterns, with address a zero-extended or truncated to DW:
  - Mode 0: a.
  - Mode 1: ~a.
  - Mode 2: 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, advanced once per word; the low DW bits are used.
  - Mode 3: {DW/8{8'h55}} for even a, {DW/8{8'hAA}} for odd a.
- An address range of i_last_addr == 0 tests exactly one word. Addresses never wrap past i_last_addr.
- i_wb_err in any phase:
  - Set o_bus_err.
  - Drop cyc and stb at the next edge and discard outstanding responses.
  - Go to DONE with o_pass=0.
- Reset in any state, including mid-burst:
  - Next edge: cyc=stb=we=0, state IDLE.
  - All status outputs 0, o_wb_addr=0, o_wb_data=0, o_wb_sel all ones.

## Timing
- i_start at edge N gives cyc=stb=1 with addr=0 and the mode-0/1/3 or seeded-LFSR data at edge N+1.
- With stall=0 and ack one cycle after accept, one word is issued per clock.
- o_wb_addr and o_wb_data change only on accept or on a state change. They are held stable while stalled.
- The first mismatch is latched on the ack edge. o_err_count updates on the same edge.
- o_done and o_pass rise on the edge after the final ack is checked; o_busy falls on that same edge.
- o_cycles increments every clock while o_busy.

## Test plan
- **Zero-latency RAM model**, AW=4, last_addr=15, mode 0: 16 writes of data == address, 16 reads, one GAP cycle between the phases. Required: o_pass=1, o_err_count=0.
- **Stalls and outstanding limit**, random stall and ack latency 1–6, LGOUT=2: never more than 4 outstanding; LFSR mode passes; write data matches a golden LFSR seeded 32'h1.
- **Fault injection**: model flips bit 3 of the word at address 5, mode 3. Required: o_err_count=1, o_err_addr=5, o_err_exp=32'hAAAAAAAA, o_err_got=32'hAAAAAAA2, o_pass=0.
- **Bus error**: assert i_wb_err on the 7th write ack. Required: cyc=0 at the next edge, o_bus_err=1, o_done=1, o_pass=0.
- **Reset mid-READ**, with 3 requests outstanding: cyc and stb low at the next edge and all status outputs 0. A subsequent start runs clean and passes.
- **Boundary cases**: last_addr=0 gives exactly 1 write and 1 read. i_start pulsed while busy has no effect. Accept and ack in the same cycle at full outstanding keep the count constant.

Source files
------------

// File: rtl/wb_memtest.sv
`default_nettype none
// ============================================================================
//  Module   : wb_memtest
//  Purpose  : Pipelined Wishbone memory-test master. It writes a pattern
//             over [0, i_last_addr], reads the range back, and reports
//             pass/fail, mismatch count, first failing word and run time.
//             Up to 2^LGOUT requests may be outstanding at once.
//  Ports    : i_clk, i_reset               clock, synchronous active-high reset
//             i_start, i_mode, i_seed,
//             i_last_addr                  test control, sampled on start
//             o_wb_* / i_wb_*              pipelined Wishbone master port
//             o_busy, o_done, o_pass       run status
//             o_bus_err, o_err_count,
//             o_err_addr/exp/got           error reporting
//             o_cycles                     clocks spent busy (saturating)
//  Revision : 1.0  initial release
// ============================================================================
module wb_memtest #(
    parameter int AW    = 19,
    parameter int DW    = 32,
    parameter int LGOUT = 3
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic [1:0]      i_mode,
    input  logic [31:0]     i_seed,
    input  logic [AW-1:0]   i_last_addr,
    output logic            o_wb_cyc,
    output logic            o_wb_stb,
    output logic            o_wb_we,
    output logic [AW-1:0]   o_wb_addr,
    output logic [DW-1:0]   o_wb_data,
    output logic [DW/8-1:0] o_wb_sel,
    input  logic            i_wb_stall,
    input  logic            i_wb_ack,
    input  logic            i_wb_err,
    input  logic [DW-1:0]   i_wb_data,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_pass,
    output logic            o_bus_err,
    output logic [15:0]     o_err_count,
    output logic [AW-1:0]   o_err_addr,
    output logic [DW-1:0]   o_err_exp,
    output logic [DW-1:0]   o_err_got,
    output logic [31:0]     o_cycles
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_WRITE  = 3'd1;
    localparam logic [2:0] c_WDRAIN = 3'd2;
    localparam logic [2:0] c_GAP    = 3'd3;
    localparam logic [2:0] c_READ   = 3'd4;
    localparam logic [2:0] c_RDRAIN = 3'd5;
    localparam logic [2:0] c_DONE   = 3'd6;

    localparam logic [LGOUT:0] c_MAXOUT  = {1'b1, {LGOUT{1'b0}}};
    localparam logic [LGOUT:0] c_OUT_ONE = {{LGOUT{1'b0}}, 1'b1};
    localparam logic [AW-1:0]  c_ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
    // Galois taps for x^32+x^22+x^2+x+1, right-shifting form.
    localparam logic [31:0]    c_TAPS = 32'h8020_0003;

    function automatic logic [31:0] f_lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ c_TAPS) : (s >> 1);
    endfunction

    function automatic logic [DW-1:0] f_pattern(input logic [1:0]    m,
                                                input logic [AW-1:0] a,
                                                input logic [31:0]   l);
        logic [DW+AW-1:0] ext;
        ext = {{DW{1'b0}}, a};  // zero-extend or truncate the address to DW
        case (m)
            2'd0:    return ext[DW-1:0];
            2'd1:    return ~ext[DW-1:0];
            2'd2:    return l[DW-1:0];
            default: return a[0] ? {(DW/8){8'hAA}} : {(DW/8){8'h55}};
        endcase
    endfunction

    logic [2:0]      r_state, w_next;
    logic [1:0]      r_mode;
    logic [31:0]     r_seed;
    logic [AW-1:0]   r_last;
    logic [AW-1:0]   r_iss_addr, r_chk_addr;
    logic [31:0]     r_iss_lfsr, r_chk_lfsr;
    logic [LGOUT:0]  r_out;
    logic [15:0]     r_err_count;
    logic [AW-1:0]   r_err_addr;
    logic [DW-1:0]   r_err_exp, r_err_got;
    logic            r_bus_err;
    logic [31:0]     r_cycles;

    logic            w_cyc, w_stb, w_we, w_busy, w_done, w_issuing;
    logic            w_ack, w_err, w_can_issue, w_accept, w_last_iss;
    logic            w_start_ok, w_chk_ack, w_mismatch;
    logic [31:0]     w_seed_eff;
    logic [DW-1:0]   w_exp;

    assign w_ack      = i_wb_ack && w_cyc;
    assign w_err      = i_wb_err && w_cyc;
    // A full pipeline may still issue when one slot frees up this cycle.
    assign w_can_issue = !r_out[LGOUT] || ((r_out == c_MAXOUT) && w_ack);
    assign w_accept   = w_stb && !i_wb_stall;
    assign w_last_iss = (r_iss_addr == r_last);
    assign w_start_ok = i_start && ((r_state == c_IDLE) || (r_state == c_DONE));
    assign w_seed_eff = (i_seed == 32'd0) ? 32'd1 : i_seed;
    assign w_chk_ack  = w_ack && !w_err && ((r_state == c_READ) || (r_state == c_RDRAIN));
    assign w_exp      = f_pattern(r_mode, r_chk_addr, r_chk_lfsr);
    assign w_mismatch = (i_wb_data != w_exp);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_state <= c_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE, c_DONE: if (i_start) w_next = c_WRITE;
            c_WRITE:  if (w_err) w_next = c_DONE;
                      else if (w_accept && w_last_iss) w_next = c_WDRAIN;
            c_WDRAIN: if (w_err) w_next = c_DONE;
                      else if (r_out == '0) w_next = c_GAP;
            c_GAP:    w_next = c_READ;
            c_READ:   if (w_err) w_next = c_DONE;
                      else if (w_accept && w_last_iss) w_next = c_RDRAIN;
            c_RDRAIN: if (w_err) w_next = c_DONE;
                      else if (r_out == '0) w_next = c_DONE;
            default:  w_next = c_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        w_issuing = (r_state == c_WRITE) || (r_state == c_READ);
        w_cyc     = w_issuing || (r_state == c_WDRAIN) || (r_state == c_RDRAIN);
        w_we      = (r_state == c_WRITE) || (r_state == c_WDRAIN);
        w_busy    = w_cyc || (r_state == c_GAP);
        w_done    = (r_state == c_DONE);
        w_stb     = w_issuing && w_can_issue;
    end

    // Datapath: generators, outstanding counter, error capture, timer
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mode      <= 2'd0;
            r_seed      <= 32'd0;
            r_last      <= '0;
            r_iss_addr  <= '0;
            r_iss_lfsr  <= 32'd0;
            r_chk_addr  <= '0;
            r_chk_lfsr  <= 32'd0;
            r_out       <= '0;
            r_err_count <= 16'd0;
            r_err_addr  <= '0;
            r_err_exp   <= '0;
            r_err_got   <= '0;
            r_bus_err   <= 1'b0;
            r_cycles    <= 32'd0;
        end else if (w_start_ok) begin
            r_mode      <= i_mode;
            r_seed      <= w_seed_eff;
            r_last      <= i_last_addr;
            r_iss_addr  <= '0;
            r_iss_lfsr  <= w_seed_eff;
            r_chk_addr  <= '0;
            r_chk_lfsr  <= w_seed_eff;
            r_out       <= '0;
            r_err_count <= 16'd0;
            r_err_addr  <= '0;
            r_err_exp   <= '0;
            r_err_got   <= '0;
            r_bus_err   <= 1'b0;
            r_cycles    <= 32'd0;
        end else begin
            if (w_busy && (r_cycles != 32'hFFFF_FFFF))
                r_cycles <= r_cycles + 32'd1;

            if (w_accept && !w_ack)
                r_out <= r_out + c_OUT_ONE;
            else if (!w_accept && w_ack)
                r_out <= r_out - c_OUT_ONE;

            // The issue address parks on the last word rather than wrapping.
            if (w_accept && !w_last_iss) begin
                r_iss_addr <= r_iss_addr + c_ADDR_ONE;
                r_iss_lfsr <= f_lfsr_step(r_iss_lfsr);
            end

            // Reload on entry to GAP so READ starts from word 0.
            if ((r_state == c_WDRAIN) && (w_next == c_GAP)) begin
                r_iss_addr <= '0;
                r_iss_lfsr <= r_seed;
            end

            if (w_chk_ack) begin
                if (r_chk_addr != r_last) begin
                    r_chk_addr <= r_chk_addr + c_ADDR_ONE;
                    r_chk_lfsr <= f_lfsr_step(r_chk_lfsr);
                end
                if (w_mismatch) begin
                    if (r_err_count == 16'd0) begin
                        r_err_addr <= r_chk_addr;
                        r_err_exp  <= w_exp;
                        r_err_got  <= i_wb_data;
                    end
                    if (r_err_count != 16'hFFFF)
                        r_err_count <= r_err_count + 16'd1;
                end
            end

            if (w_err)
                r_bus_err <= 1'b1;
        end
    end

    assign o_wb_cyc    = w_cyc;
    assign o_wb_stb    = w_stb;
    assign o_wb_we     = w_we;
    assign o_wb_addr   = r_iss_addr;
    assign o_wb_data   = f_pattern(r_mode, r_iss_addr, r_iss_lfsr);
    assign o_wb_sel    = '1;
    assign o_busy      = w_busy;
    assign o_done      = w_done;
    assign o_pass      = w_done && (r_err_count == 16'd0) && !r_bus_err;
    assign o_bus_err   = r_bus_err;
    assign o_err_count = r_err_count;
    assign o_err_addr  = r_err_addr;
    assign o_err_exp   = r_err_exp;
    assign o_err_got   = r_err_got;
    assign o_cycles    = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_wb_memtest.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_memtest
//  Purpose  : Directed self-checking bench for wb_memtest, driving a
//             pipelined Wishbone RAM model with configurable stall, ack
//             latency, bit-flip and bus-error injection.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_memtest;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int LGOUT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic i_reset = 1'b1, i_start = 1'b0;
    logic [1:0] i_mode = 2'd0;
    logic [31:0] i_seed = 32'd0;
    logic [AW-1:0] i_last_addr = '0;
    logic o_wb_cyc, o_wb_stb, o_wb_we;
    logic [AW-1:0] o_wb_addr;
    logic [DW-1:0] o_wb_data;
    logic [DW/8-1:0] o_wb_sel;
    logic i_wb_stall = 1'b0, i_wb_ack = 1'b0, i_wb_err = 1'b0;
    logic [DW-1:0] i_wb_data = '0;
    logic o_busy, o_done, o_pass, o_bus_err;
    logic [15:0] o_err_count;
    logic [AW-1:0] o_err_addr;
    logic [DW-1:0] o_err_exp, o_err_got;
    logic [31:0] o_cycles;

    wb_memtest #(.AW(AW), .DW(DW), .LGOUT(LGOUT)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_mode(i_mode),
        .i_seed(i_seed), .i_last_addr(i_last_addr),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
        .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
        .i_wb_data(i_wb_data),
        .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_bus_err(o_bus_err),
        .o_err_count(o_err_count), .o_err_addr(o_err_addr),
        .o_err_exp(o_err_exp), .o_err_got(o_err_got), .o_cycles(o_cycles)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Slave model configuration and observations
    bit cfg_stall = 0;
    int cfg_lat_min = 1, cfg_lat_max = 1;
    int cfg_flip = -1;
    int cfg_err_wack = 0;
    int exp_mode = 0;
    logic [31:0] g_lfsr = 32'd1;
    int n_wr, n_rd, wr_bad, rd_bad, max_out, full_same, gap_n, wacks;
    int cyc_n = 0;
    bit err_fired;
    logic [31:0] mem [0:255];

    typedef struct {
        int          due;
        logic [31:0] data;
        bit          we;
    } resp_t;
    resp_t q[$];

    function automatic logic [31:0] bstep(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 32'h8020_0003;
        return n;
    endfunction

    function automatic logic [31:0] bpat(input int m, input int a, input logic [31:0] l);
        case (m)
            0:       return 32'(a);
            1:       return ~32'(a);
            2:       return l;
            default: return (a % 2 == 1) ? 32'hAAAA_AAAA : 32'h5555_5555;
        endcase
    endfunction

    // Pipelined Wishbone RAM: inputs change at negedge, requests sampled 1ns later.
    initial begin
        resp_t r;
        int lat, due, pre;
        bit acked;
        logic [31:0] d;
        forever begin
            @(negedge clk);
            cyc_n++;
            if (!o_wb_cyc) q.delete();
            i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_data = '0; acked = 0;
            if (q.size() > 0 && q[0].due <= cyc_n) begin
                r = q.pop_front();
                acked = 1;
                if (r.we) wacks++;
                if (r.we && cfg_err_wack != 0 && wacks == cfg_err_wack) begin
                    i_wb_err = 1'b1; err_fired = 1;
                end else begin
                    i_wb_ack = 1'b1; i_wb_data = r.data;
                end
            end
            pre = q.size() + (acked ? 1 : 0);
            i_wb_stall = cfg_stall ? ($urandom_range(0, 2) == 0) : 1'b0;
            #1;
            if (o_busy && !o_wb_cyc) gap_n++;
            if (o_wb_cyc && o_wb_stb && !i_wb_stall) begin
                if (pre == (1 << LGOUT) && acked) full_same++;
                if (o_wb_we) begin
                    if (o_wb_addr !== AW'(n_wr) || o_wb_data !== bpat(exp_mode, n_wr, g_lfsr))
                        wr_bad++;
                    g_lfsr = bstep(g_lfsr);
                    mem[o_wb_addr] = o_wb_data;
                    n_wr++;
                    d = 32'd0;
                end else begin
                    if (o_wb_addr !== AW'(n_rd)) rd_bad++;
                    d = mem[o_wb_addr];
                    if (int'(o_wb_addr) == cfg_flip) d = d ^ 32'h8;
                    n_rd++;
                end
                lat = $urandom_range(cfg_lat_min, cfg_lat_max);
                due = cyc_n + lat;
                if (q.size() > 0 && q[$].due >= due) due = q[$].due + 1;
                r.due = due; r.data = d; r.we = o_wb_we;
                q.push_back(r);
                if (q.size() > max_out) max_out = q.size();
            end
        end
    end

    task automatic start_run(input int mode, input logic [31:0] seed, input int last);
        @(negedge clk); #2;
        n_wr = 0; n_rd = 0; wr_bad = 0; rd_bad = 0; max_out = 0; full_same = 0;
        gap_n = 0; wacks = 0; err_fired = 0;
        exp_mode = mode;
        g_lfsr = (seed == 32'd0) ? 32'd1 : seed;
        i_mode = 2'(mode); i_seed = seed; i_last_addr = AW'(last); i_start = 1'b1;
        @(negedge clk); #2;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #2;
            if (o_done) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset;
        i_reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        n_checks++; if ({o_wb_cyc, o_wb_stb, o_wb_we} !== 3'b000) $display("FAIL rst_bus: got %b want 000", {o_wb_cyc, o_wb_stb, o_wb_we}); else n_pass++;
        n_checks++; if ({o_busy, o_done, o_pass, o_bus_err} !== 4'b0000) $display("FAIL rst_status: got %b want 0000", {o_busy, o_done, o_pass, o_bus_err}); else n_pass++;
        n_checks++; if (o_err_count !== 16'd0) $display("FAIL rst_errcnt: got %0h want 0", o_err_count); else n_pass++;
        n_checks++; if ({o_err_addr, o_err_exp, o_err_got} !== '0) $display("FAIL rst_errinfo: got %0h/%0h/%0h want 0", o_err_addr, o_err_exp, o_err_got); else n_pass++;
        n_checks++; if (o_cycles !== 32'd0) $display("FAIL rst_cycles: got %0d want 0", o_cycles); else n_pass++;
        n_checks++; if ({o_wb_addr, o_wb_data} !== '0) $display("FAIL rst_addr_data: got %0h/%0h want 0/0", o_wb_addr, o_wb_data); else n_pass++;
        n_checks++; if (o_wb_sel !== 4'hF) $display("FAIL rst_sel: got %0h want f", o_wb_sel); else n_pass++;
        i_reset = 1'b0;
    endtask

    task automatic test_zero_latency;
        bit ok;
        cfg_stall = 0; cfg_lat_min = 1; cfg_lat_max = 1;
        start_run(0, 32'd0, 15);
        n_checks++; if ({o_wb_cyc, o_wb_stb, o_wb_we} !== 3'b111) $display("FAIL zl_first_ctl: got %b want 111", {o_wb_cyc, o_wb_stb, o_wb_we}); else n_pass++;
        n_checks++; if ({o_wb_addr, o_wb_data} !== {8'd0, 32'd0}) $display("FAIL zl_first_word: got %0h/%0h want 0/0", o_wb_addr, o_wb_data); else n_pass++;
        wait_done(300, ok);
        n_checks++; if (!ok) $display("FAIL zl_timeout: got no done want done"); else n_pass++;
        n_checks++; if ({o_pass, o_err_count} !== {1'b1, 16'd0}) $display("FAIL zl_pass: got pass=%b cnt=%0d want 1/0", o_pass, o_err_count); else n_pass++;
        n_checks++; if (n_wr != 16 || n_rd != 16) $display("FAIL zl_counts: got wr=%0d rd=%0d want 16/16", n_wr, n_rd); else n_pass++;
        n_checks++; if (wr_bad != 0 || rd_bad != 0) $display("FAIL zl_seq: got wbad=%0d rbad=%0d want 0/0", wr_bad, rd_bad); else n_pass++;
        n_checks++; if (gap_n != 1) $display("FAIL zl_gap: got %0d want 1", gap_n); else n_pass++;
        n_checks++; if (o_cycles !== 32'd37) $display("FAIL zl_cycles: got %0d want 37", o_cycles); else n_pass++;
        repeat (3) @(negedge clk);
        #2;
        n_checks++; if ({o_done, o_busy, o_cycles} !== {1'b1, 1'b0, 32'd37}) $display("FAIL zl_hold: got done=%b busy=%b cyc=%0d want 1/0/37", o_done, o_busy, o_cycles); else n_pass++;
    endtask

    task automatic test_stall_lfsr;
        bit ok;
        cfg_stall = 1; cfg_lat_min = 1; cfg_lat_max = 6;
        start_run(2, 32'd1, 40);
        n_checks++; if (o_wb_data !== 32'd1) $display("FAIL st_first_data: got %0h want 1", o_wb_data); else n_pass++;
        wait_done(3000, ok);
        n_checks++; if (!ok) $display("FAIL st_timeout: got no done want done"); else n_pass++;
        n_checks++; if (o_pass !== 1'b1) $display("FAIL st_pass: got %b want 1", o_pass); else n_pass++;
        n_checks++; if (max_out > 4) $display("FAIL st_maxout: got %0d want <=4", max_out); else n_pass++;
        n_checks++; if (wr_bad != 0 || n_wr != 41 || n_rd != 41) $display("FAIL st_wdata: got bad=%0d wr=%0d rd=%0d want 0/41/41", wr_bad, n_wr, n_rd); else n_pass++;
        cfg_stall = 0;
    endtask

    task automatic test_full_same;
        bit ok;
        cfg_stall = 0; cfg_lat_min = 4; cfg_lat_max = 4;
        start_run(2, 32'd0, 20);
        n_checks++; if (o_wb_data !== 32'd1) $display("FAIL fs_seed0: got %0h want 1", o_wb_data); else n_pass++;
        wait_done(500, ok);
        n_checks++; if (!ok || o_pass !== 1'b1) $display("FAIL fs_pass: got done=%b pass=%b want 1/1", ok, o_pass); else n_pass++;
        n_checks++; if (max_out != 4) $display("FAIL fs_maxout: got %0d want 4", max_out); else n_pass++;
        n_checks++; if (full_same == 0) $display("FAIL fs_same_cycle: got 0 events want >0"); else n_pass++;
        n_checks++; if (wr_bad != 0) $display("FAIL fs_wdata: got %0d bad want 0", wr_bad); else n_pass++;
    endtask

    task automatic test_fault;
        bit ok;
        cfg_lat_min = 1; cfg_lat_max = 1; cfg_flip = 5;
        start_run(3, 32'd0, 15);
        wait_done(300, ok);
        n_checks++; if (!ok) $display("FAIL flt_timeout: got no done want done"); else n_pass++;
        n_checks++; if (o_err_count !== 16'd1) $display("FAIL flt_count: got %0d want 1", o_err_count); else n_pass++;
        n_checks++; if (o_err_addr !== 8'd5) $display("FAIL flt_addr: got %0d want 5", o_err_addr); else n_pass++;
        n_checks++; if (o_err_exp !== 32'hAAAA_AAAA) $display("FAIL flt_exp: got %0h want aaaaaaaa", o_err_exp); else n_pass++;
        n_checks++; if (o_err_got !== 32'hAAAA_AAA2) $display("FAIL flt_got: got %0h want aaaaaaa2", o_err_got); else n_pass++;
        n_checks++; if ({o_pass, o_bus_err} !== 2'b00) $display("FAIL flt_pass: got pass=%b berr=%b want 0/0", o_pass, o_bus_err); else n_pass++;
        cfg_flip = -1;
    endtask

    task automatic test_bus_err;
        bit seen;
        cfg_lat_min = 1; cfg_lat_max = 1; cfg_err_wack = 7;
        start_run(0, 32'd0, 15);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (err_fired) begin seen = 1; break; end
        end
        @(negedge clk); #2;
        n_checks++; if (!seen) $display("FAIL berr_timeout: got no err want err"); else n_pass++;
        n_checks++; if ({o_wb_cyc, o_wb_stb} !== 2'b00) $display("FAIL berr_cyc: got %b want 00", {o_wb_cyc, o_wb_stb}); else n_pass++;
        n_checks++; if ({o_bus_err, o_done, o_pass, o_busy} !== 4'b1100) $display("FAIL berr_status: got %b want 1100", {o_bus_err, o_done, o_pass, o_busy}); else n_pass++;
        cfg_err_wack = 0;
    endtask

    task automatic test_reset_midread;
        bit hit, ok;
        cfg_lat_min = 4; cfg_lat_max = 4;
        start_run(0, 32'd0, 31);
        hit = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #2;
            if (o_wb_cyc && !o_wb_we && q.size() == 3) begin hit = 1; break; end
        end
        n_checks++; if (!hit) $display("FAIL rmr_reach: got not reached want 3 outstanding in read"); else n_pass++;
        i_reset = 1'b1;
        @(negedge clk); #2;
        n_checks++; if ({o_wb_cyc, o_wb_stb, o_wb_we} !== 3'b000) $display("FAIL rmr_bus: got %b want 000", {o_wb_cyc, o_wb_stb, o_wb_we}); else n_pass++;
        n_checks++; if ({o_busy, o_done, o_pass, o_bus_err, o_err_count, o_cycles} !== '0) $display("FAIL rmr_status: got busy=%b done=%b cnt=%0d cyc=%0d want 0", o_busy, o_done, o_err_count, o_cycles); else n_pass++;
        i_reset = 1'b0;
        cfg_lat_min = 1; cfg_lat_max = 1;
        start_run(1, 32'd0, 15);
        n_checks++; if (o_wb_data !== 32'hFFFF_FFFF) $display("FAIL rmr_first_data: got %0h want ffffffff", o_wb_data); else n_pass++;
        wait_done(300, ok);
        n_checks++; if (!ok || o_pass !== 1'b1 || n_wr != 16 || n_rd != 16 || wr_bad != 0) $display("FAIL rmr_rerun: got done=%b pass=%b wr=%0d rd=%0d bad=%0d want 1/1/16/16/0", ok, o_pass, n_wr, n_rd, wr_bad); else n_pass++;
    endtask

    task automatic test_one_word;
        bit ok;
        cfg_lat_min = 1; cfg_lat_max = 1;
        start_run(0, 32'd0, 0);
        wait_done(100, ok);
        n_checks++; if (!ok || o_pass !== 1'b1) $display("FAIL ow_pass: got done=%b pass=%b want 1/1", ok, o_pass); else n_pass++;
        n_checks++; if (n_wr != 1 || n_rd != 1) $display("FAIL ow_counts: got wr=%0d rd=%0d want 1/1", n_wr, n_rd); else n_pass++;
    endtask

    task automatic test_start_busy;
        bit ok;
        cfg_lat_min = 2; cfg_lat_max = 2;
        start_run(3, 32'd0, 15);
        repeat (5) @(negedge clk);
        #2;
        i_mode = 2'd0; i_last_addr = 8'd3; i_start = 1'b1;
        @(negedge clk); #2;
        i_start = 1'b0;
        wait_done(400, ok);
        n_checks++; if (!ok || o_pass !== 1'b1) $display("FAIL sb_pass: got done=%b pass=%b want 1/1", ok, o_pass); else n_pass++;
        n_checks++; if (n_wr != 16 || n_rd != 16 || wr_bad != 0) $display("FAIL sb_counts: got wr=%0d rd=%0d bad=%0d want 16/16/0", n_wr, n_rd, wr_bad); else n_pass++;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_zero_latency();
        test_stall_lfsr();
        test_full_same();
        test_fault();
        test_bus_err();
        test_reset_midread();
        test_one_word();
        test_start_busy();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
